pf_iod_eye_monitor_trainer: RTL and testbench
=============================================

// Module: pf_iod_eye_monitor_trainer
// PURPOSE
//  Fabric-side controller for the far end of the IOD eye-monitor/delay-line interface of a
//  DDRX RX clock-training lane. Clears the sticky EARLY/LATE flags, integrates them over a
//  window, and steps the RX delay line one tap at a time until the sampling point is centred.
//  Sits beside the RX IOD wrapper and drives its CLEAR_FLAGS/MOVE/DIRECTION/LOAD pins.
// PARAMETERS
//  SETTLE_CYCLES  8    FAB_CLK cycles waited after a clear/move before sampling (>=1)
//  SAMPLE_CYCLES  16   FAB_CLK cycles of flag integration per decision (>=1)
//  LOCK_COUNT     4    consecutive "neither flag" decisions required for lock (1..15)
//  INIT_TAP       1    tap value the IOD delay line takes on DELAY_LINE_LOAD
//  MAX_TAP        127  highest legal tap (7-bit counter)
//  MAX_ITER       255  decision budget per training run before TRAIN_ERROR
// PORTS
//  FAB_CLK                  in   1  fabric clock, same clock as the IOD RX_CLK
//  ARST                     in   1  asynchronous active-high reset
//  TRAIN_START              in   1  1-cycle pulse; starts or restarts training
//  EYE_MONITOR_EARLY        in   1  sticky early flag from IOD
//  EYE_MONITOR_LATE         in   1  sticky late flag from IOD
//  DELAY_LINE_OUT_OF_RANGE  in   1  IOD delay-line overflow indicator
//  EYE_MONITOR_CLEAR_FLAGS  out  1  1-cycle clear pulse to IOD
//  DELAY_LINE_LOAD          out  1  1-cycle load pulse (delay line -> INIT_TAP)
//  DELAY_LINE_MOVE          out  1  1-cycle step pulse
//  DELAY_LINE_DIRECTION     out  1  1 = add delay, 0 = remove delay; valid with MOVE
//  TAP_COUNT                out  7  fabric shadow of current tap
//  BUSY                     out  1  training in progress
//  TRAIN_DONE               out  1  level, lock achieved
//  TRAIN_ERROR              out  1  level, training failed
// BEHAVIOUR
//  Reset: state IDLE; all pulses 0, DIRECTION 0, TAP_COUNT=INIT_TAP, BUSY/DONE/ERROR 0.
//  All outputs registered. States: IDLE, LOAD, CLEAR, SETTLE, SAMPLE, DECIDE, MOVE, LOCKED, ERROR.
//  IDLE/LOCKED/ERROR + TRAIN_START -> LOAD; DONE, ERROR, balance cnt, iter cnt cleared; BUSY=1.
//  TRAIN_START in any other state is ignored.
//  LOAD (1 cyc): LOAD=1, TAP_COUNT<=INIT_TAP -> CLEAR.
//  CLEAR (1 cyc): CLEAR_FLAGS=1, early/late accumulators cleared -> SETTLE.
//  SETTLE: SETTLE_CYCLES cycles, flags ignored -> SAMPLE.
//  SAMPLE: SAMPLE_CYCLES cycles; acc_e|=EARLY, acc_l|=LATE each cycle -> DECIDE.
//  DECIDE (1 cyc): iter++; priority order:
//   OUT_OF_RANGE=1 or iter==MAX_ITER -> ERROR
//   acc_e&!acc_l: if TAP_COUNT==MAX_TAP -> ERROR else dir=1, bal=0 -> MOVE
//   acc_l&!acc_e: if TAP_COUNT==0 -> ERROR else dir=0, bal=0 -> MOVE
//   both set: bal=0 -> CLEAR (no move; edge jitter)
//   neither: bal++; bal==LOCK_COUNT -> LOCKED else -> CLEAR
//  MOVE (1 cyc): MOVE=1, DIRECTION=dir (held after until next MOVE); TAP_COUNT +/-1 -> CLEAR.
//  LOCKED: DONE=1, BUSY=0, stays until TRAIN_START. ERROR: ERROR=1, BUSY=0, same exit.
//  OUT_OF_RANGE sampled only in DECIDE. TAP_COUNT never wraps (guarded above).
//  ARST mid-run: immediate return to reset values; no partial pulse completes.
//  Decision loop latency w/o move: 1+SETTLE+SAMPLE+1 cycles; with move +1.
// TESTING
//  T1 flags tied 0, TRAIN_START -> LOAD @+1, CLEAR @+2, DONE after 4 loops (104 cyc), TAP=1.
//  T2 EARLY=1 until TAP=10 then 0 -> 9 MOVE pulses DIR=1, TAP=10, then lock, DONE=1.
//  T3 LATE=1 from TAP=1 -> 1 MOVE DIR=0, TAP=0, next LATE decision -> ERROR=1, no MOVE.
//  T4 both flags=1 constantly -> no MOVE, ERROR=1 after MAX_ITER decisions; TAP=1.
//  T5 ARST during SAMPLE, then TRAIN_START during SETTLE -> reset values; restart ignored.
//  T6 OUT_OF_RANGE=1 during DECIDE -> ERROR next cycle; then TRAIN_START re-trains to DONE.

Source files
------------

// File: rtl/pf_iod_eye_monitor_trainer.sv
// Fabric-side trainer for the IOD eye monitor / RX delay line: clears the sticky flags, integrates
// them over a window and steps the delay line one tap at a time until neither flag fires LOCK_COUNT times.
module pf_iod_eye_monitor_trainer #(
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned SAMPLE_CYCLES = 16,
  parameter int unsigned LOCK_COUNT    = 4,
  parameter logic [6:0]  INIT_TAP      = 7'd1,
  parameter logic [6:0]  MAX_TAP       = 7'd127,
  parameter int unsigned MAX_ITER      = 255
) (
  input  logic       FAB_CLK,
  input  logic       ARST,
  input  logic       TRAIN_START,
  input  logic       EYE_MONITOR_EARLY,
  input  logic       EYE_MONITOR_LATE,
  input  logic       DELAY_LINE_OUT_OF_RANGE,
  output logic       EYE_MONITOR_CLEAR_FLAGS,
  output logic       DELAY_LINE_LOAD,
  output logic       DELAY_LINE_MOVE,
  output logic       DELAY_LINE_DIRECTION,
  output logic [6:0] TAP_COUNT,
  output logic       BUSY,
  output logic       TRAIN_DONE,
  output logic       TRAIN_ERROR
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_CLEAR, S_SETTLE, S_SAMPLE, S_DECIDE, S_MOVE, S_LOCKED, S_ERROR
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  iter_q, iter_d;
  logic [3:0]  bal_q, bal_d;
  logic        acc_e_q, acc_e_d, acc_l_q, acc_l_d;
  logic        dir_q, dir_d;
  logic [6:0]  tap_q, tap_d;
  logic        clear_q, load_q, move_q, busy_q, done_q, err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    iter_d  = iter_q;
    bal_d   = bal_q;
    acc_e_d = acc_e_q;
    acc_l_d = acc_l_q;
    dir_d   = dir_q;
    tap_d   = tap_q;
    case (state_q)
      S_IDLE, S_LOCKED, S_ERROR: begin
        if (TRAIN_START) begin
          state_d = S_LOAD;
          tap_d   = INIT_TAP;
          iter_d  = '0;
          bal_d   = '0;
        end
      end
      S_LOAD: state_d = S_CLEAR;
      S_CLEAR: begin
        acc_e_d = 1'b0;
        acc_l_d = 1'b0;
        cnt_d   = '0;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == 16'(SETTLE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        acc_e_d = acc_e_q | EYE_MONITOR_EARLY;
        acc_l_d = acc_l_q | EYE_MONITOR_LATE;
        cnt_d   = cnt_q + 16'd1;
        if (cnt_q == 16'(SAMPLE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_DECIDE;
        end
      end
      S_DECIDE: begin
        iter_d = iter_q + 8'd1;
        if (DELAY_LINE_OUT_OF_RANGE || (iter_d == 8'(MAX_ITER))) begin
          state_d = S_ERROR;
        end else if (acc_e_q && !acc_l_q) begin
          bal_d = '0;
          if (tap_q == MAX_TAP) begin
            state_d = S_ERROR;
          end else begin
            dir_d   = 1'b1;
            tap_d   = tap_q + 7'd1;
            state_d = S_MOVE;
          end
        end else if (acc_l_q && !acc_e_q) begin
          bal_d = '0;
          if (tap_q == 7'd0) begin
            state_d = S_ERROR;
          end else begin
            dir_d   = 1'b0;
            tap_d   = tap_q - 7'd1;
            state_d = S_MOVE;
          end
        end else if (acc_e_q && acc_l_q) begin
          // Both flags means the sample point straddles edge jitter: re-measure, don't move.
          bal_d   = '0;
          state_d = S_CLEAR;
        end else begin
          bal_d   = bal_q + 4'd1;
          state_d = (bal_d == 4'(LOCK_COUNT)) ? S_LOCKED : S_CLEAR;
        end
      end
      S_MOVE:  state_d = S_CLEAR;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each pulse lines up with its state.
  always_ff @(posedge FAB_CLK or posedge ARST) begin
    if (ARST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      iter_q  <= '0;
      bal_q   <= '0;
      acc_e_q <= 1'b0;
      acc_l_q <= 1'b0;
      dir_q   <= 1'b0;
      tap_q   <= INIT_TAP;
      clear_q <= 1'b0;
      load_q  <= 1'b0;
      move_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      iter_q  <= iter_d;
      bal_q   <= bal_d;
      acc_e_q <= acc_e_d;
      acc_l_q <= acc_l_d;
      dir_q   <= dir_d;
      tap_q   <= tap_d;
      clear_q <= (state_d == S_CLEAR);
      load_q  <= (state_d == S_LOAD);
      move_q  <= (state_d == S_MOVE);
      busy_q  <= !(state_d inside {S_IDLE, S_LOCKED, S_ERROR});
      done_q  <= (state_d == S_LOCKED);
      err_q   <= (state_d == S_ERROR);
    end
  end

  assign EYE_MONITOR_CLEAR_FLAGS = clear_q;
  assign DELAY_LINE_LOAD         = load_q;
  assign DELAY_LINE_MOVE         = move_q;
  assign DELAY_LINE_DIRECTION    = dir_q;
  assign TAP_COUNT               = tap_q;
  assign BUSY                    = busy_q;
  assign TRAIN_DONE              = done_q;
  assign TRAIN_ERROR             = err_q;

endmodule

// File: tb/tb_pf_iod_eye_monitor_trainer.sv
// Directed bench for pf_iod_eye_monitor_trainer; n counts rising edges since TRAIN_START was sampled.
// One decision loop is 26 edges (CLEAR+8 SETTLE+16 SAMPLE+DECIDE), 27 when it ends in a MOVE.
module tb_pf_iod_eye_monitor_trainer;

  logic       FAB_CLK = 1'b0;
  logic       ARST = 1'b1;
  logic       TRAIN_START = 1'b0;
  logic       early_r = 1'b0, late_r = 1'b0, early_mode = 1'b0;
  logic       EYE_MONITOR_EARLY, EYE_MONITOR_LATE;
  logic       DELAY_LINE_OUT_OF_RANGE = 1'b0;
  logic       EYE_MONITOR_CLEAR_FLAGS, DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION;
  logic [6:0] TAP_COUNT;
  logic       BUSY, TRAIN_DONE, TRAIN_ERROR;

  int n_tests = 0, n_fail = 0;
  int moves = 0, loads = 0, n = 0;
  logic last_dir = 1'b0;

  always #5 FAB_CLK = ~FAB_CLK;

  // In early_mode EARLY stays high until the delay line reaches tap 10.
  assign EYE_MONITOR_EARLY = early_mode ? (TAP_COUNT < 7'd10) : early_r;
  assign EYE_MONITOR_LATE  = late_r;

  pf_iod_eye_monitor_trainer dut (
    .FAB_CLK(FAB_CLK), .ARST(ARST), .TRAIN_START(TRAIN_START),
    .EYE_MONITOR_EARLY(EYE_MONITOR_EARLY), .EYE_MONITOR_LATE(EYE_MONITOR_LATE),
    .DELAY_LINE_OUT_OF_RANGE(DELAY_LINE_OUT_OF_RANGE),
    .EYE_MONITOR_CLEAR_FLAGS(EYE_MONITOR_CLEAR_FLAGS), .DELAY_LINE_LOAD(DELAY_LINE_LOAD),
    .DELAY_LINE_MOVE(DELAY_LINE_MOVE), .DELAY_LINE_DIRECTION(DELAY_LINE_DIRECTION),
    .TAP_COUNT(TAP_COUNT), .BUSY(BUSY), .TRAIN_DONE(TRAIN_DONE), .TRAIN_ERROR(TRAIN_ERROR)
  );

  always @(posedge FAB_CLK) begin
    if (DELAY_LINE_MOVE) begin
      moves++;
      last_dir = DELAY_LINE_DIRECTION;
    end
    if (DELAY_LINE_LOAD) loads++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pulses"}, {29'd0, EYE_MONITOR_CLEAR_FLAGS, DELAY_LINE_LOAD, DELAY_LINE_MOVE}, 0);
    check({tag, "_dir"}, DELAY_LINE_DIRECTION, 0);
    check({tag, "_tap"}, TAP_COUNT, 1);
    check({tag, "_status"}, {29'd0, BUSY, TRAIN_DONE, TRAIN_ERROR}, 0);
  endtask

  // Leaves n = 1 at the negedge after the edge that sampled TRAIN_START.
  task automatic start();
    @(negedge FAB_CLK);
    moves = 0;
    loads = 0;
    TRAIN_START = 1'b1;
    @(negedge FAB_CLK);
    TRAIN_START = 1'b0;
    n = 1;
  endtask

  task automatic wait_end(input int lim);
    while (!(TRAIN_DONE || TRAIN_ERROR) && n < lim) begin
      @(negedge FAB_CLK);
      n++;
    end
    check("wait_bound", n < lim, 1);
  endtask

  initial begin
    repeat (2) @(negedge FAB_CLK);
    check_reset_vals("reset");
    ARST = 1'b0;

    // T1: quiet flags -> 4 neither-decisions -> lock; OOR outside DECIDE is ignored.
    start();
    check("t1_load_pulse", DELAY_LINE_LOAD, 1);
    check("t1_busy", BUSY, 1);
    @(negedge FAB_CLK); n++;
    check("t1_clear_pulse", EYE_MONITOR_CLEAR_FLAGS, 1);
    check("t1_load_gone", DELAY_LINE_LOAD, 0);
    DELAY_LINE_OUT_OF_RANGE = 1'b1;
    repeat (3) begin @(negedge FAB_CLK); n++; end
    DELAY_LINE_OUT_OF_RANGE = 1'b0;
    wait_end(400);
    check("t1_done_cycle", n, 106);
    check("t1_done", TRAIN_DONE, 1);
    check("t1_err", TRAIN_ERROR, 0);
    check("t1_busy_off", BUSY, 0);
    check("t1_tap", TAP_COUNT, 1);
    check("t1_moves", moves, 0);

    // T2: EARLY until tap 10 -> 9 upward moves, then lock.
    early_mode = 1'b1;
    start();
    wait_end(1000);
    check("t2_done_cycle", n, 1 + 9 * 27 + 4 * 26 + 1);
    check("t2_done", TRAIN_DONE, 1);
    check("t2_moves", moves, 9);
    check("t2_dir", last_dir, 1);
    check("t2_tap", TAP_COUNT, 10);
    early_mode = 1'b0;

    // T3: LATE from tap 1 -> one move down to 0, then ERROR without a move.
    late_r = 1'b1;
    start();
    check("t3_tap_reload", TAP_COUNT, 1);
    wait_end(400);
    check("t3_err", TRAIN_ERROR, 1);
    check("t3_err_cycle", n, 1 + 27 + 26 + 1);
    check("t3_moves", moves, 1);
    check("t3_dir", DELAY_LINE_DIRECTION, 0);
    check("t3_tap", TAP_COUNT, 0);

    // T4: both flags -> never moves, ERROR on decision 255.
    early_r = 1'b1;
    start();
    check("t4_err_cleared", TRAIN_ERROR, 0);
    wait_end(8000);
    check("t4_err", TRAIN_ERROR, 1);
    check("t4_err_cycle", n, 1 + 255 * 26 + 1);
    check("t4_moves", moves, 0);
    check("t4_tap", TAP_COUNT, 1);
    early_r = 1'b0;
    late_r  = 1'b0;

    // T5: ARST in SAMPLE clears everything at once; TRAIN_START in SETTLE is ignored.
    start();
    while (n < 15) begin @(negedge FAB_CLK); n++; end
    check("t5_busy_pre", BUSY, 1);
    ARST = 1'b1;
    #1;
    check_reset_vals("t5_arst");
    @(negedge FAB_CLK);
    ARST = 1'b0;
    start();
    while (n < 5) begin @(negedge FAB_CLK); n++; end
    TRAIN_START = 1'b1;
    @(negedge FAB_CLK); n++;
    TRAIN_START = 1'b0;
    wait_end(400);
    check("t5_done_cycle", n, 106);
    check("t5_done", TRAIN_DONE, 1);
    check("t5_loads", loads, 1);

    // T6: OOR in the first DECIDE -> ERROR; then a clean retrain locks.
    DELAY_LINE_OUT_OF_RANGE = 1'b1;
    start();
    check("t6_done_cleared", TRAIN_DONE, 0);
    wait_end(400);
    check("t6_err", TRAIN_ERROR, 1);
    check("t6_err_cycle", n, 28);
    DELAY_LINE_OUT_OF_RANGE = 1'b0;
    start();
    check("t6_err_cleared", TRAIN_ERROR, 0);
    wait_end(400);
    check("t6_done", TRAIN_DONE, 1);
    check("t6_done_cycle", n, 106);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
